// File: rtl/dpmem_pkg.sv
// dpmem_pkg: shared types and constants for the dual-port bank memory.
package dpmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dpmem_state_e;

  localparam int MAX_READ_LATENCY = 4;
  localparam int BYTE_W           = 8;

endpackage

// File: rtl/dpmem_rd_pipe.sv
// dpmem_rd_pipe: read-data delay line. Each stage captures data only when
// its incoming valid is set, so the last stage holds the most recent read.
module dpmem_rd_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DEPTH-1:0]      r_vld;
  logic [DATA_WIDTH-1:0] r_dat [DEPTH];

  // Shift valid every cycle; move data forward only alongside a valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_dat[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_data  = r_dat[DEPTH-1];

endmodule

// File: rtl/dualport_bank_mem.sv
// dualport_bank_mem: single-clock memory with one byte-masked write port,
// one pipelined read port and a self-clearing sequencer.
// Optional macro DPMEM_BYPASS_EN: same-address read/write collisions return
// the freshly written bytes (write-first); otherwise the old word is returned.
//
// state | meaning
// CLEAR | zeroing one word per cycle from address 0; ready low, requests dropped
// READY | normal operation; clr_req starts a new clear
module dualport_bank_mem
  import dpmem_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_req,
  output logic                           ready,
  input  logic                           w_en,
  input  logic [DATA_WIDTH/BYTE_W-1:0]   w_be,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic                           r_req,
  input  logic [ADDR_WIDTH-1:0]          r_addr,
  output logic                           r_valid,
  output logic [DATA_WIDTH-1:0]          r_data
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("dualport_bank_mem: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("dualport_bank_mem: READ_LATENCY must be in 1..4");
  end

  dpmem_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_sample;

  assign w_wr_acc = r_ready & w_en;
  assign w_rd_acc = r_ready & r_req;
  assign w_rd_old = r_mem[r_addr];
  assign ready    = r_ready;

  // Sequencer: walk the clear counter to the top address, then serve requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_cnt == '1) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            r_state   <= CLEAR;
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: clear zeroes have priority; user writes only when ready.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (w_be[b]) r_mem[w_addr][b*BYTE_W +: BYTE_W] <= w_data[b*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef DPMEM_BYPASS_EN
  // Forward the enabled write bytes into a same-address read.
  always_comb begin
    w_rd_sample = w_rd_old;
    if (w_wr_acc && (w_addr == r_addr)) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (w_be[b]) w_rd_sample[b*BYTE_W +: BYTE_W] = w_data[b*BYTE_W +: BYTE_W];
      end
    end
  end
`else
  assign w_rd_sample = w_rd_old;
`endif

  dpmem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_acc),
    .i_data  (w_rd_sample),
    .o_valid (r_valid),
    .o_data  (r_data)
  );

endmodule

// File: tb/tb_dualport_bank_mem.sv
// tb_dualport_bank_mem: table vectors, hand sequences and random traffic
// checked against an array/queue reference model.
module tb_dualport_bank_mem;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RL = 3;
  localparam int NW = 16;

`ifdef DPMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_req = 1'b0;
  logic          ready;
  logic          w_en = 1'b0;
  logic [3:0]    w_be = '0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          r_req = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic          r_valid;
  logic [DW-1:0] r_data;

  dualport_bank_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
    .w_en(w_en), .w_be(w_be), .w_addr(w_addr), .w_data(w_data),
    .r_req(r_req), .r_addr(r_addr), .r_valid(r_valid), .r_data(r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rq;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    bit          has_tab;
    logic [DW-1:0] tab;
  } rd_t;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [DW-1:0] model [NW];
  bit            m_ready;
  int            m_clr_left;
  logic [DW-1:0] m_last;
  rd_t           pend[$];
  vec_t          tab[18];

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [3:0] be);
    logic [DW-1:0] res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  function automatic vec_t mk(logic we, logic [3:0] be, int wa, logic [DW-1:0] wd,
                              logic rq, int ra, logic [DW-1:0] exp);
    vec_t v;
    v.we = we; v.be = be; v.wa = AW'(wa); v.wd = wd;
    v.rq = rq; v.ra = AW'(ra); v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
  endtask

  // Runs one clock cycle: drive, check current outputs, advance the model, wait.
  task automatic cycle(input logic we, input logic [3:0] be, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic rq, input logic [AW-1:0] ra,
                       input logic clr, input bit has_tab = 1'b0,
                       input logic [DW-1:0] tv = '0);
    rd_t e;
    logic [DW-1:0] s;
    w_en = we; w_be = be; w_addr = wa; w_data = wd;
    r_req = rq; r_addr = ra; clr_req = clr;
    chk("ready", DW'(ready), DW'(m_ready));
    if (pend.size() > 0 && pend[0].due == cyc) begin
      chk("r_valid", DW'(r_valid), 1);
      chk("r_data_model", r_data, pend[0].data);
      if (pend[0].has_tab) chk("r_data_table", r_data, pend[0].tab);
      m_last = pend[0].data;
      void'(pend.pop_front());
    end else begin
      chk("r_valid", DW'(r_valid), 0);
      chk("r_data_hold", r_data, m_last);
    end
    if (m_ready) begin
      if (rq) begin
        s = model[ra];
        if (BYP && we && wa == ra) s = merge(s, wd, be);
        e.due = cyc + RL; e.data = s; e.has_tab = has_tab; e.tab = tv;
        pend.push_back(e);
      end
      if (we) model[wa] = merge(model[wa], wd, be);
      if (clr) begin
        m_ready = 1'b0;
        m_clr_left = NW;
        for (int i = 0; i < NW; i++) model[i] = '0;
      end
    end else begin
      m_clr_left--;
      if (m_clr_left == 0) m_ready = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cycle(input int clr_pct);
    cycle(1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom), $urandom,
          1'($urandom_range(0, 1)), AW'($urandom),
          1'($urandom_range(0, 99) < clr_pct));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w_en = 0; r_req = 0; clr_req = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", DW'(ready), 0);
    chk("rst_r_valid", DW'(r_valid), 0);
    chk("rst_r_data", r_data, 0);
    pend.delete();
    m_ready = 1'b0;
    m_clr_left = NW;
    m_last = '0;
    for (int i = 0; i < NW; i++) model[i] = '0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tab[0]  = mk(1, 4'hF, 3, 32'hA5A5A5A5, 0, 0, 0);
    tab[1]  = mk(1, 4'h1, 3, 32'h000000FF, 0, 0, 0);
    tab[2]  = mk(1, 4'hF, 0, 32'h11111111, 0, 0, 0);
    tab[3]  = mk(1, 4'hF, 1, 32'h22222222, 0, 0, 0);
    tab[4]  = mk(1, 4'hF, 2, 32'h33333333, 0, 0, 0);
    tab[5]  = mk(1, 4'hF, 4, 32'h44444444, 1, 3, 32'hA5A5A5FF);
    tab[6]  = mk(0, 4'h0, 0, 0, 1, 0, 32'h11111111);
    tab[7]  = mk(0, 4'h0, 0, 0, 1, 1, 32'h22222222);
    tab[8]  = mk(0, 4'h0, 0, 0, 1, 2, 32'h33333333);
    tab[9]  = mk(0, 4'h0, 0, 0, 1, 3, 32'hA5A5A5FF);
    tab[10] = mk(0, 4'h0, 0, 0, 1, 4, 32'h44444444);
    tab[11] = mk(1, 4'hF, 7, 32'h00001234, 1, 7, BYP ? 32'h00001234 : 32'h0);
    tab[12] = mk(0, 4'h0, 0, 0, 1, 7, 32'h00001234);
    tab[13] = mk(0, 4'h0, 0, 0, 1, 9, 32'h0);
    tab[14] = mk(1, 4'hF, 9, 32'hDEADBEEF, 0, 0, 0);
    tab[15] = mk(1, 4'h6, 10, 32'hAABBCCDD, 1, 10, BYP ? 32'h00BBCC00 : 32'h0);
    tab[16] = mk(0, 4'h0, 0, 0, 1, 10, 32'h00BBCC00);
    tab[17] = mk(0, 4'h0, 0, 0, 1, 9, 32'hDEADBEEF);

    @(negedge clk);
    do_reset();

    // Power-up clear, then every word reads back as zero.
    idle(NW);
    for (int a = 0; a < NW; a++) cycle(0, 0, 0, 0, 1, AW'(a), 0, 1'b1, 32'h0);
    idle(RL + 1);

    for (int i = 0; i < 18; i++)
      cycle(tab[i].we, tab[i].be, tab[i].wa, tab[i].wd, tab[i].rq, tab[i].ra, 0,
            tab[i].rq, tab[i].exp);
    idle(RL + 1);

    // Fill, clear with reads in flight, traffic during clear is dropped.
    for (int a = 0; a < NW; a++) cycle(1, 4'hF, AW'(a), $urandom, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 5, 0);
    cycle(1, 4'hF, 2, 32'h0BADF00D, 1, 6, 1);
    for (int i = 0; i < NW; i++) rnd_cycle(30);
    for (int a = 0; a < NW; a++) cycle(0, 0, 0, 0, 1, AW'(a), 0, 1'b1, 32'h0);
    idle(RL + 1);

    for (int i = 0; i < 400; i++) rnd_cycle(3);
    idle(NW + RL + 1);

    // Reset in the middle of a clear restarts it from address 0.
    do_reset();
    for (int i = 0; i < 8; i++) rnd_cycle(0);
    do_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      cycle(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    chk("clear_len_after_rst", DW'(n), DW'(NW));
    for (int a = 0; a < NW; a++) cycle(0, 0, 0, 0, 1, AW'(a), 0, 1'b1, 32'h0);
    idle(RL + 1);

    // Reset while reads are in flight drops them.
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 2, 0);
    do_reset();
    idle(NW + RL + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dualport_bank_mem.md
DUALPORT_BANK_MEM -- requirements
Module: dualport_bank_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, request-to-data cycles, legal range 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clr_req  input  1  one-cycle pulse requesting a full zero-clear.
REQ-007 SHALL have port ready  output  1  high when accepting reads/writes (state READY).
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port w_be  input  DATA_WIDTH/8  byte enables; bit i covers w_data[8i+7:8i].
REQ-010 SHALL have port w_addr  input  ADDR_WIDTH  write address.
REQ-011 SHALL have port w_data  input  DATA_WIDTH  write data.
REQ-012 SHALL have port r_req  input  1  read request.
REQ-013 SHALL have port r_addr  input  ADDR_WIDTH  read address.
REQ-014 SHALL have port r_valid  output  1  one-cycle strobe marking r_data valid.
REQ-015 SHALL have port r_data  output  DATA_WIDTH  read data.

Function
REQ-016 SHALL implement FSM states CLEAR and READY; CLEAR->READY after last address written; READY->CLEAR on clr_req.
REQ-017 In CLEAR, SHALL write all-zero to one address per cycle, counter 0..2**ADDR_WIDTH-1, ready low.
REQ-018 clr_req during CLEAR SHALL be ignored; clear is not restarted.
REQ-019 w_en/r_req while ready low SHALL be dropped: no array write, no r_valid generated.
REQ-020 In READY, w_en SHALL update only bytes with w_be bit set at w_addr, at the rising edge.
REQ-021 r_req sampled in cycle N SHALL produce r_valid=1 and r_data in cycle N+READ_LATENCY, r_valid high exactly one cycle.
REQ-022 Back-to-back r_req every cycle SHALL yield r_valid every cycle, in request order, no bubbles.
REQ-023 Array content SHALL be sampled in the request cycle; writes after cycle N SHALL not affect that read's data.
REQ-024 r_data SHALL hold its last valid value while r_valid low.
REQ-025 Read and write to different addresses in the same cycle SHALL both complete with no interaction.
REQ-026 Read requests in flight when clr_req is accepted SHALL still complete with their sampled data.

Reset
REQ-027 rst high SHALL force ready=0, r_valid=0, r_data=0, read pipeline cleared, clear counter=0, state CLEAR.
REQ-028 After rst release, SHALL run a full clear; ready rises 2**ADDR_WIDTH cycles after the first clock edge with rst low.
REQ-029 rst asserted mid-clear or mid-read SHALL abort everything and restart the clear from address 0.

Configuration
REQ-030 Macro DPMEM_BYPASS_EN defined: same-cycle read and write to the same address SHALL return the new data merged per w_be (write-first).
REQ-031 DPMEM_BYPASS_EN undefined: same-cycle collision SHALL return pre-write content (read-first); no forwarding mux synthesised.

Structure
REQ-032 Package dpmem_pkg SHALL hold the FSM state typedef (CLEAR, READY) and constants MAX_READ_LATENCY=4 and BYTE_W=8.
REQ-033 Read delay line SHALL be a sub-module dpmem_rd_pipe (valid+data shift, depth READ_LATENCY).
REQ-034 Elaboration SHALL fail on DATA_WIDTH not a multiple of 8 or READ_LATENCY outside 1..4.

Verification
REQ-035 ADDR_WIDTH=4: release rst -> ready low 16 cycles then high; reads of all 16 addresses return 0.
REQ-036 Write 0xA5..A5 all bytes to addr 3, then w_be=0x1 with data 0xFF at addr 3 -> read addr 3 gives 0xA5..A5FF.
REQ-037 READ_LATENCY=3, r_req on 5 consecutive cycles to addrs 0..4 -> r_valid 5 consecutive cycles starting 3 cycles later, data in order.
REQ-038 Same-cycle write 0x1234 and read addr 7 (old 0) -> 0x1234 with DPMEM_BYPASS_EN, 0 without.
REQ-039 clr_req after filling addrs 0..15 -> ready low 16 cycles, writes during it dropped, then all reads 0.
REQ-040 Assert rst at clear address 8 -> after release, clear restarts at 0; ready rises after a full 16 cycles.
